// File: rtl/axo_mem_arbiter_if.sv
// Axo memory bus: the CPU modport issues an access, the MEM modport answers it.
interface axo_mem_bus;
    logic [31:0] addr;
    logic [1:0]  asize;
    logic        we;
    logic        re;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ready;
    logic        error;

    modport CPU (output addr, asize, we, re, wdata, input rdata, ready, error);
    modport MEM (input addr, asize, we, re, wdata, output rdata, ready, error);
endinterface

// File: rtl/axo_mem_arbiter.sv
// Two-port arbiter (fetch=req0, data=req1) onto one Axo memory port; grant held for a whole access.
// Optional access timeout compiled in with `define AXO_ARB_TIMEOUT_EN.
module axo_mem_arbiter #(
    parameter int          FIXED_PRIO     = 0,
    parameter int          STARVE_LIMIT   = 4,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] TIMEOUT_CODE   = 32'hFFFF_FFFF
) (
    input  logic    clk,
    input  logic    rst_n,
    axo_mem_bus.MEM req0,
    axo_mem_bus.MEM req1,
    axo_mem_bus.CPU mem
);
    localparam int SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

    logic          r_owner;
    logic [SW-1:0] r_starve;

    logic        w_act0, w_act1, w_own_act, w_oth_act;
    logic        w_tmo_fire, w_done, w_policy, w_switch;
    logic        w_rdy, w_err;
    logic [31:0] w_rdata;

    assign w_act0    = req0.re | req0.we;
    assign w_act1    = req1.re | req1.we;
    assign w_own_act = r_owner ? w_act1 : w_act0;
    assign w_oth_act = r_owner ? w_act0 : w_act1;
    assign w_done    = w_own_act & (mem.ready | w_tmo_fire);

    // Under fixed priority port 0 yields only once port 1 has waited STARVE_LIMIT completions.
    assign w_policy  = (FIXED_PRIO == 0) | r_owner | (r_starve == SW'(STARVE_LIMIT - 1));
    assign w_switch  = w_oth_act & (~w_own_act | (w_done & w_policy));

`ifdef AXO_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo;

    assign w_tmo_fire = w_own_act & ~mem.ready & (r_tmo == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo <= '0;
        end else if (!w_own_act || w_done || w_switch) begin
            r_tmo <= '0;
        end else begin
            r_tmo <= r_tmo + TW'(1);
        end
    end
`else
    // Feature compiled out: constant 0, still tied to TIMEOUT_CYCLES so the parameter is referenced.
    assign w_tmo_fire = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_owner  <= 1'b0;
            r_starve <= '0;
        end else begin
            if (w_switch) r_owner <= ~r_owner;
            if (!w_act1 || (w_switch && !r_owner)) begin
                r_starve <= '0;
            end else if (!r_owner && w_done && (r_starve != SW'(STARVE_LIMIT))) begin
                r_starve <= r_starve + SW'(1);
            end
        end
    end

    always_comb begin
        mem.addr  = '0;
        mem.asize = '0;
        mem.wdata = '0;
        mem.re    = 1'b0;
        mem.we    = 1'b0;
        if (rst_n && w_own_act) begin
            if (r_owner) begin
                mem.addr  = req1.addr;
                mem.asize = req1.asize;
                mem.wdata = req1.wdata;
                mem.re    = req1.re & ~w_tmo_fire;
                mem.we    = req1.we & ~w_tmo_fire;
            end else begin
                mem.addr  = req0.addr;
                mem.asize = req0.asize;
                mem.wdata = req0.wdata;
                mem.re    = req0.re & ~w_tmo_fire;
                mem.we    = req0.we & ~w_tmo_fire;
            end
        end
    end

    assign w_rdy   = mem.ready | w_tmo_fire;
    assign w_err   = mem.error | w_tmo_fire;
    assign w_rdata = w_tmo_fire ? TIMEOUT_CODE : mem.rdata;

    always_comb begin
        req0.ready = 1'b0;
        req0.error = 1'b0;
        req0.rdata = '0;
        req1.ready = 1'b0;
        req1.error = 1'b0;
        req1.rdata = '0;
        if (rst_n) begin
            if (r_owner) begin
                req1.ready = w_rdy;
                req1.error = w_err;
                req1.rdata = w_rdata;
            end else begin
                req0.ready = w_rdy;
                req0.error = w_err;
                req0.rdata = w_rdata;
            end
        end
    end
endmodule

// File: tb/tb_axo_mem_arbiter.sv
// Bench for axo_mem_arbiter: round-robin (u_rr) and fixed-priority (u_fp) instances on shared stimulus.
module tb_axo_mem_arbiter;
    localparam int STV = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_re [2];
    logic        s_we [2];
    logic [31:0] s_addr [2];
    logic [1:0]  s_asize [2];
    logic [31:0] s_wdata [2];
    logic        s_mrdy, s_merr;
    logic [31:0] s_mrd;

    axo_mem_bus b0_rr(), b1_rr(), m_rr(), b0_fp(), b1_fp(), m_fp();

    assign {b0_rr.re, b0_rr.we, b0_rr.addr, b0_rr.asize, b0_rr.wdata} = {s_re[0], s_we[0], s_addr[0], s_asize[0], s_wdata[0]};
    assign {b1_rr.re, b1_rr.we, b1_rr.addr, b1_rr.asize, b1_rr.wdata} = {s_re[1], s_we[1], s_addr[1], s_asize[1], s_wdata[1]};
    assign {b0_fp.re, b0_fp.we, b0_fp.addr, b0_fp.asize, b0_fp.wdata} = {s_re[0], s_we[0], s_addr[0], s_asize[0], s_wdata[0]};
    assign {b1_fp.re, b1_fp.we, b1_fp.addr, b1_fp.asize, b1_fp.wdata} = {s_re[1], s_we[1], s_addr[1], s_asize[1], s_wdata[1]};
    assign {m_rr.rdata, m_rr.ready, m_rr.error} = {s_mrd, s_mrdy, s_merr};
    assign {m_fp.rdata, m_fp.ready, m_fp.error} = {s_mrd, s_mrdy, s_merr};

    axo_mem_arbiter #(.FIXED_PRIO(0), .STARVE_LIMIT(STV), .TIMEOUT_CYCLES(TMO), .TIMEOUT_CODE(32'hFFFF_FFFF))
        u_rr (.clk(clk), .rst_n(rst_n), .req0(b0_rr), .req1(b1_rr), .mem(m_rr));
    axo_mem_arbiter #(.FIXED_PRIO(1), .STARVE_LIMIT(STV), .TIMEOUT_CYCLES(TMO), .TIMEOUT_CODE(32'hFFFF_FFFF))
        u_fp (.clk(clk), .rst_n(rst_n), .req0(b0_fp), .req1(b1_fp), .mem(m_fp));

    logic [135:0] got_v [2];
    assign got_v[0] = {m_rr.re, m_rr.we, m_rr.addr, m_rr.asize, m_rr.wdata,
                       b0_rr.ready, b0_rr.error, b0_rr.rdata, b1_rr.ready, b1_rr.error, b1_rr.rdata};
    assign got_v[1] = {m_fp.re, m_fp.we, m_fp.addr, m_fp.asize, m_fp.wdata,
                       b0_fp.ready, b0_fp.error, b0_fp.rdata, b1_fp.ready, b1_fp.error, b1_fp.rdata};

    int n_chk = 0;
    int n_err = 0;

    // Reference model: who holds the port, how many port-0 wins port 1 has sat through, stall age.
    bit m_own [2];
    int m_stv [2];
    int m_tmo [2];

    task automatic chk(input string nm, input logic [135:0] got, input logic [135:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", nm, got, exp);
        end
    endtask

    function automatic logic act(input bit p);
        return s_re[p] | s_we[p];
    endfunction

    function automatic logic tmo_hit(input int d, input logic a);
        logic hit;
        hit = a && !s_mrdy && (m_tmo[d] == TMO - 1);
`ifdef AXO_ARB_TIMEOUT_EN
        return hit;
`else
        return 1'b0 & hit;
`endif
    endfunction

    function automatic logic [135:0] exp_vec(input int d);
        bit          o;
        logic        a, fire;
        logic [1:0]  prdy, perr;
        logic [31:0] prd [2];
        o    = m_own[d];
        a    = act(o);
        fire = tmo_hit(d, a);
        prdy = '0;
        perr = '0;
        prd[0] = '0;
        prd[1] = '0;
        prdy[o] = s_mrdy | fire;
        perr[o] = s_merr | fire;
        prd[o]  = fire ? 32'hFFFF_FFFF : s_mrd;
        return {a & ~fire & s_re[o], a & ~fire & s_we[o], a ? s_addr[o] : 32'h0,
                a ? s_asize[o] : 2'b00, a ? s_wdata[o] : 32'h0,
                prdy[0], perr[0], prd[0], prdy[1], perr[1], prd[1]};
    endfunction

    task automatic step_model();
        for (int d = 0; d < 2; d++) begin
            bit   o;
            logic a_own, a_oth, done, pol, sw;
            o     = m_own[d];
            a_own = act(o);
            a_oth = act(!o);
            done  = a_own && (s_mrdy || tmo_hit(d, a_own));
            pol   = (d == 0) || o || (m_stv[d] == STV - 1);
            sw    = a_oth && (!a_own || (done && pol));
            if (!act(1) || (sw && !o)) m_stv[d] = 0;
            else if (!o && done && m_stv[d] < STV) m_stv[d]++;
            if (!a_own || done || sw) m_tmo[d] = 0;
            else m_tmo[d]++;
            if (sw) m_own[d] = !o;
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_own[d] = 1'b0;
            m_stv[d] = 0;
            m_tmo[d] = 0;
        end
    endtask

    // Called with inputs already driven at a negedge: check both DUTs, advance model, move one cycle.
    task automatic tick();
        #2;
        if (rst_n) begin
            chk("model_rr", got_v[0], exp_vec(0));
            chk("model_fp", got_v[1], exp_vec(1));
        end
        step_model();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        for (int p = 0; p < 2; p++) begin
            s_re[p]  = 1'b0;
            s_we[p]  = 1'b0;
            s_wdata[p] = 32'h0;
        end
        s_addr[0]  = 32'h10;
        s_addr[1]  = 32'h20;
        s_asize[0] = 2'd2;
        s_asize[1] = 2'd1;
        s_mrdy = 1'b0;
        s_merr = 1'b0;
        s_mrd  = 32'h0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #2;
        chk("reset_rr", got_v[0], 136'h0);
        chk("reset_fp", got_v[1], 136'h0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic        re0, re1, rdy;
        logic        e_mre;
        logic [31:0] e_addr;
        logic        e_r0, e_r1, e_own;
    } vec_t;

    vec_t tbl [13];

    initial begin
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1};
        tbl[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
        tbl[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1, 32'h20, 1'b0, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1};
        tbl[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h00, 1'b0, 1'b0, 1'b1};
        tbl[12] = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h20, 1'b0, 1'b1, 1'b1};

        idle_inputs();
        model_reset();
        @(negedge clk);
        do_reset();

        // Directed table on the round-robin instance
        for (int i = 0; i < 13; i++) begin
            s_re[0] = tbl[i].re0;
            s_re[1] = tbl[i].re1;
            s_mrdy  = tbl[i].rdy;
            s_mrd   = 32'hA5A5_0000 + 32'(i);
            #1;
            chk($sformatf("tbl%0d", i),
                {m_rr.re, m_rr.addr, b0_rr.ready, b1_rr.ready, b0_rr.rdata, b1_rr.rdata},
                {tbl[i].e_mre, tbl[i].e_addr, tbl[i].e_r0, tbl[i].e_r1,
                 tbl[i].e_own ? 32'h0 : s_mrd, tbl[i].e_own ? s_mrd : 32'h0});
            tick();
        end

        // Continuous contention, memory always ready: RR alternates, FP gives 4:1
        do_reset();
        s_re[0] = 1'b1;
        s_re[1] = 1'b1;
        s_mrdy  = 1'b1;
        for (int i = 0; i < 15; i++) begin
            s_mrd = 32'h0C0D_E000 + 32'(i);
            #1;
            chk($sformatf("rr_alt%0d", i), {b0_rr.ready, b1_rr.ready}, (i % 2 == 0) ? 2'b10 : 2'b01);
            chk($sformatf("fp_4to1_%0d", i), {b0_fp.ready, b1_fp.ready}, (i % 5 == 4) ? 2'b01 : 2'b10);
            tick();
        end

        // Port-0 write stalled 5 cycles while port 1 waits: grant locked, then handed over
        do_reset();
        s_we[0]    = 1'b1;
        s_addr[0]  = 32'h44;
        s_wdata[0] = 32'h1234_5678;
        s_re[1]    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("lock%0d", i), {m_rr.we, m_rr.re, m_rr.addr, m_rr.wdata, b1_rr.ready},
                {1'b1, 1'b0, 32'h44, 32'h1234_5678, 1'b0});
            tick();
        end
        s_mrdy = 1'b1;
        #1;
        chk("lock_done", {b0_rr.ready, m_rr.addr}, {1'b1, 32'h44});
        tick();
        s_mrdy = 1'b0;
        #1;
        chk("handover", {m_rr.re, m_rr.addr}, {1'b1, 32'h20});
        #1;

        // Reset in the middle of port 1's stall: bus strobes and responses drop at once
        s_mrdy = 1'b1;
        s_merr = 1'b1;
        rst_n  = 1'b0;
        #1;
        chk("rst_async_rr", {m_rr.re, m_rr.we, b0_rr.ready, b0_rr.error, b1_rr.ready, b1_rr.error}, 6'b0);
        chk("rst_async_fp", {m_fp.re, m_fp.we, b0_fp.ready, b0_fp.error, b1_fp.ready, b1_fp.error}, 6'b0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        #1;
        chk("post_rst_idle", {m_rr.re, m_rr.we, m_rr.addr, b0_rr.ready, b1_rr.ready}, 36'h0);
        tick();
        s_re[0] = 1'b1;
        s_re[1] = 1'b1;
        #1;
        chk("post_rst_owner0", {m_rr.addr, m_fp.addr}, {32'h10, 32'h10});
        tick();

`ifdef AXO_ARB_TIMEOUT_EN
        // Port 0 stalled forever: aborted on the 8th cycle, port 1 granted next on RR
        do_reset();
        s_re[0] = 1'b1;
        s_re[1] = 1'b1;
        s_mrd   = 32'h5555_AAAA;
        for (int k = 1; k <= TMO; k++) begin
            #1;
            if (k < TMO)
                chk($sformatf("tmo_wait%0d", k), {b0_rr.ready, b0_rr.error, m_rr.re}, 3'b001);
            else
                chk("tmo_fire", {b0_rr.ready, b0_rr.error, b0_rr.rdata, m_rr.re},
                    {1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0});
            tick();
        end
        #1;
        chk("tmo_next_gnt", {m_rr.re, m_rr.addr}, {1'b1, 32'h20});
        tick();
`endif

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 400; i++) begin
            for (int p = 0; p < 2; p++) begin
                int r;
                r = $urandom_range(0, 3);
                s_re[p]    = (r == 1) || (r == 3);
                s_we[p]    = (r == 2);
                s_addr[p]  = $urandom;
                s_asize[p] = 2'($urandom_range(0, 3));
                s_wdata[p] = $urandom;
            end
            s_mrdy = ($urandom_range(0, 3) != 0);
            s_merr = ($urandom_range(0, 7) == 0);
            s_mrd  = $urandom;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
